ex_mul_sequencer: RTL
=====================

// Module: ex_mul_sequencer
// PURPOSE
//   Execute-stage sequencer that owns the shared ALU/operand-mux path of EX.
//   Single-cycle ALU ops pass through with fixed 2-cycle latency; MUL ops are run
//   iteratively (shift-add) reusing the same ALU adder, one bit per cycle.
//   Sits between ID/EX operand registers and the ALU; stalls ID while busy.
// PARAMETERS
//   WIDTH    32      datapath width; MUL latency scales with it
//   ALU_ADD  3'b010  ALU_Sel code for addition, driven during MUL iterations
// PORTS
//   i_clk          in   1      clock; all state on rising edge
//   i_rst          in   1      synchronous, active-high reset
//   i_valid        in   1      op request from ID/EX
//   o_ready        out  1      1 = can accept op this cycle (IDLE only)
//   i_op_mul       in   1      1 = multiply, 0 = plain ALU op
//   i_ALUControl   in   3      ALU_Sel for plain ops
//   i_ALUSrc       in   1      plain op: B = i_constante if 1, else i_register2
//   i_register1    in   WIDTH  operand A / multiplicand
//   i_register2    in   WIDTH  operand B / multiplier
//   i_constante    in   WIDTH  immediate
//   i_flush        in   1      abort in-flight op (branch taken / trap)
//   o_alu_a        out  WIDTH  to ALU.A
//   o_alu_b        out  WIDTH  to ALU.B
//   o_alu_sel      out  3      to ALU.ALU_Sel
//   i_alu_result   in   WIDTH  from ALU.ALU_Out (combinational)
//   i_alu_zero     in   1      from ALU.Zero
//   o_valid        out  1      one-cycle pulse: o_result/o_zero valid
//   o_result       out  WIDTH  result; holds until next o_valid
//   o_zero         out  1      result == 0
//   o_stall        out  1      = i_valid & ~o_ready (combinational, to hazard unit)
// BEHAVIOUR
//   States: IDLE, EXEC, MUL. Reset -> IDLE; o_valid=0, o_result=0, o_zero=0,
//   all operand/acc/count regs 0. o_ready=1 iff state==IDLE.
//   IDLE: i_valid & ~i_flush -> capture A, B (mux by i_ALUSrc; mul always reg2),
//     sel, count=0, acc=0; go EXEC (i_op_mul=0) or MUL (i_op_mul=1).
//   EXEC (1 cycle): ALU driven from captured regs; register i_alu_result ->
//     o_result, i_alu_zero -> o_zero, o_valid=1 next cycle; go IDLE.
//     Latency: accept at T, o_valid at T+2. New op acceptable at T+2 (throughput 1/2).
//   MUL (exactly WIDTH cycles, no early exit): ALU a=acc, b=mcand, sel=ALU_ADD.
//     each cycle: if mplier[0] acc<=i_alu_result; mcand<<=1; mplier>>=1; count++.
//     count==WIDTH-1 -> final update, o_result<=acc' (low WIDTH bits, wraps),
//     o_zero<=(acc'==0), o_valid=1 next cycle; go IDLE. accept T -> o_valid T+WIDTH+1.
//   count width $clog2(WIDTH)+1. Unsigned/low-half product == signed low half.
//   IDLE ALU drive: a=0, b=0, sel=ALU_ADD (no spurious toggling).
//   i_valid while not ready: ignored, not queued; o_stall=1; requester must hold.
//   i_flush: in EXEC/MUL -> IDLE next cycle, no o_valid, o_result/o_zero unchanged.
//     In IDLE, flush beats i_valid: op not accepted.
//   i_rst mid-op: reset wins over everything, including flush and o_valid.
//   o_valid is a registered pulse, never high two consecutive cycles for one op.
// TESTING
//   Reset: hold i_rst 2 cycles w/ i_valid=1 -> o_valid=0,o_result=0,o_ready=1, no capture.
//   ALU add: A=5, const=7, ALUSrc=1, ctrl=010 at T -> o_valid@T+2, o_result=12, o_zero=0.
//   ALU sub back-to-back: 9-9 (ctrl 110) at T, 3+4 at T+2 -> zero=1@T+2, 7@T+4.
//   MUL 6*7 at T -> o_ready=0 T+1..T+32, o_valid@T+33 result 42; i_valid@T+5 -> o_stall=1, dropped.
//   MUL wrap/zero: 0xFFFFFFFF*2 -> 0xFFFFFFFE, zero=0; 0*0x1234 -> 0, zero=1.
//   Flush at T+10 of MUL -> no o_valid, o_ready=1@T+11, o_result keeps previous value.

Source files
------------

// File: rtl/ex_mul_sequencer_if.sv
// EX-stage bundle: ID/EX request, shared ALU path and result.
// slave = sequencer side, master = pipeline/ALU side.
interface ex_mul_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             i_valid;
   logic             o_ready;
   logic             i_op_mul;
   logic [2:0]       i_ALUControl;
   logic             i_ALUSrc;
   logic [WIDTH-1:0] i_register1;
   logic [WIDTH-1:0] i_register2;
   logic [WIDTH-1:0] i_constante;
   logic             i_flush;
   logic [WIDTH-1:0] o_alu_a;
   logic [WIDTH-1:0] o_alu_b;
   logic [2:0]       o_alu_sel;
   logic [WIDTH-1:0] i_alu_result;
   logic             i_alu_zero;
   logic             o_valid;
   logic [WIDTH-1:0] o_result;
   logic             o_zero;
   logic             o_stall;

   modport slave (
      input  i_valid, i_op_mul, i_ALUControl, i_ALUSrc,
      input  i_register1, i_register2, i_constante, i_flush,
      input  i_alu_result, i_alu_zero,
      output o_ready, o_alu_a, o_alu_b, o_alu_sel,
      output o_valid, o_result, o_zero, o_stall
   );

   modport master (
      output i_valid, i_op_mul, i_ALUControl, i_ALUSrc,
      output i_register1, i_register2, i_constante, i_flush,
      output i_alu_result, i_alu_zero,
      input  o_ready, o_alu_a, o_alu_b, o_alu_sel,
      input  o_valid, o_result, o_zero, o_stall
   );
endinterface

// File: rtl/ex_mul_sequencer.sv
// EX sequencer: 2-cycle ALU pass-through and shift-add MUL
// reusing the shared ALU adder, one multiplier bit per cycle.
module ex_mul_sequencer #(
   parameter int         WIDTH   = 32,
   parameter logic [2:0] ALU_ADD = 3'b010
) (
   input logic              i_clk,
   input logic              i_rst,
   ex_mul_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_MUL  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       sel_q, sel_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] acc_nxt;

   // In MUL, a_q holds the shifting multiplicand, b_q the multiplier
   assign acc_nxt = b_q[0] ? bus.i_alu_result : acc_q;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sel_d    = sel_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      valid_d  = 1'b0;
      result_d = result_q;
      zero_d   = zero_q;
      case (state_q)
         S_IDLE: begin
            if (bus.i_valid && !bus.i_flush) begin
               a_d   = bus.i_register1;
               b_d   = (bus.i_op_mul || !bus.i_ALUSrc) ?
                       bus.i_register2 : bus.i_constante;
               sel_d = bus.i_ALUControl;
               cnt_d = '0;
               acc_d = '0;
               state_d = bus.i_op_mul ? S_MUL : S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_IDLE;
            if (!bus.i_flush) begin
               result_d = bus.i_alu_result;
               zero_d   = bus.i_alu_zero;
               valid_d  = 1'b1;
            end
         end
         S_MUL: begin
            if (bus.i_flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = acc_nxt;
               a_d   = a_q << 1;
               b_d   = b_q >> 1;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  result_d = acc_nxt;
                  zero_d   = (acc_nxt == '0);
                  valid_d  = 1'b1;
                  state_d  = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.o_alu_a   = '0;
      bus.o_alu_b   = '0;
      bus.o_alu_sel = ALU_ADD;
      case (state_q)
         S_EXEC: begin
            bus.o_alu_a   = a_q;
            bus.o_alu_b   = b_q;
            bus.o_alu_sel = sel_q;
         end
         S_MUL: begin
            bus.o_alu_a   = acc_q;
            bus.o_alu_b   = a_q;
            bus.o_alu_sel = ALU_ADD;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sel_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sel_q    <= sel_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.o_ready  = (state_q == S_IDLE);
   assign bus.o_stall  = bus.i_valid & ~bus.o_ready;
   assign bus.o_valid  = valid_q;
   assign bus.o_result = result_q;
   assign bus.o_zero   = zero_q;
endmodule
